dma_arbiter: RTL and testbench

DMA_ARBITER -- requirements
Module: dma_arbiter

---
 rtl/dma_arbiter_if.sv | 52 +++++
 rtl/dma_arbiter.sv | 140 ++++++++++++++
 tb/tb_dma_arbiter.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter_if
// Description : MPU-side and memory-side bus bundle for the DMA arbiter.
//               The master modport is taken by the arbiter itself: it receives
//               the MPU strobes and memory read data, and it drives the shared
//               memory bus, the MPU read data, MPU ready and the busy flag.
//               The slave modport is the view of the surrounding system
//               (MPU core plus memory).
//
//   MPU side
//     CPU_R_W     MPU read(1) / write(0) strobe
//     CPU_ABL     MPU address low byte
//     CPU_ABH     MPU address high byte
//     CPU_DB_OUT  MPU write data
//     CPU_DB_IN   MPU read data (always equal to MEM_DB_IN)
//     CPU_RDY     MPU ready, 0 stalls the MPU
//   Memory side
//     MEM_DB_IN   memory read data
//     MEM_R_W     memory read(1) / write(0) strobe
//     MEM_ABL     memory address low byte
//     MEM_ABH     memory address high byte
//     MEM_DB_OUT  memory write data
//   Status
//     BUSY        a DMA is pending or running
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_arbiter_if;
    logic       CPU_R_W;
    logic [7:0] CPU_ABL;
    logic [7:0] CPU_ABH;
    logic [7:0] CPU_DB_OUT;
    logic [7:0] CPU_DB_IN;
    logic       CPU_RDY;
    logic [7:0] MEM_DB_IN;
    logic       MEM_R_W;
    logic [7:0] MEM_ABL;
    logic [7:0] MEM_ABH;
    logic [7:0] MEM_DB_OUT;
    logic       BUSY;

    modport master (
        input  CPU_R_W, CPU_ABL, CPU_ABH, CPU_DB_OUT, MEM_DB_IN,
        output CPU_DB_IN, CPU_RDY, MEM_R_W, MEM_ABL, MEM_ABH, MEM_DB_OUT, BUSY
    );

    modport slave (
        output CPU_R_W, CPU_ABL, CPU_ABH, CPU_DB_OUT, MEM_DB_IN,
        input  CPU_DB_IN, CPU_RDY, MEM_R_W, MEM_ABL, MEM_ABH, MEM_DB_OUT, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_arbiter
// Description : Sprite-style page DMA between the MPU and a shared memory bus.
//               An MPU write to TRIG_ADDR latches the written byte as a source
//               page and requests the bus. The MPU is stalled (CPU_RDY=0) and
//               keeps the bus while it is still writing; at its first read
//               cycle the arbiter takes over and copies the 256 bytes of the
//               page, one read/write pair per byte, to the fixed DEST_ADDR.
//
//   Parameters
//     TRIG_ADDR  MPU write address that starts a DMA
//     DEST_ADDR  destination address of every DMA write
//   Ports
//     CLK        clock, all state changes on the rising edge
//     RES_N      synchronous active-low reset
//     bus        dma_arbiter_if.master (MPU strobes in, memory bus out,
//                CPU_DB_IN / CPU_RDY / BUSY out)
// Revision    : 1.0 - initial release
// ============================================================================
module dma_arbiter #(
    parameter logic [15:0] TRIG_ADDR = 16'h4014,
    parameter logic [15:0] DEST_ADDR = 16'h2004
) (
    input  wire logic     CLK,
    input  wire logic     RES_N,
    dma_arbiter_if.master bus
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_HALT  = 2'd1;
    localparam logic [1:0] c_ST_READ  = 2'd2;
    localparam logic [1:0] c_ST_WRITE = 2'd3;

    localparam logic [7:0] c_DEST_ABH = DEST_ADDR[15:8];
    localparam logic [7:0] c_DEST_ABL = DEST_ADDR[7:0];
    localparam logic [7:0] c_CNT_LAST = 8'hFF;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [7:0] r_pg;
    logic [7:0] r_cnt;
    logic [7:0] r_buf;

    logic       w_trigger;
    logic       w_mem_r_w;
    logic [7:0] w_mem_abl;
    logic [7:0] w_mem_abh;
    logic [7:0] w_mem_db_out;

    // A trigger is only recognised while idle; writes to TRIG_ADDR during a
    // pending or running transfer are plain memory writes.
    assign w_trigger = (r_state == c_ST_IDLE) && !bus.CPU_R_W
                       && ({bus.CPU_ABH, bus.CPU_ABL} == TRIG_ADDR);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            r_state <= c_ST_IDLE;
            r_pg    <= 8'h00;
            r_cnt   <= 8'h00;
            r_buf   <= 8'h00;
        end else begin
            r_state <= w_state_nxt;
            if (w_trigger) begin
                r_pg  <= bus.CPU_DB_OUT;
                r_cnt <= 8'h00;
            end
            if (r_state == c_ST_READ) begin
                r_buf <= bus.MEM_DB_IN;
            end
            // Counter is 8 bits wide and never touches r_pg, so the source
            // address wraps inside the page rather than spilling into the next.
            if (r_state == c_ST_WRITE) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state and bus multiplexer
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_mem_r_w    = bus.CPU_R_W;
        w_mem_abl    = bus.CPU_ABL;
        w_mem_abh    = bus.CPU_ABH;
        w_mem_db_out = bus.CPU_DB_OUT;

        case (r_state)
            c_ST_IDLE: begin
                if (w_trigger) begin
                    w_state_nxt = c_ST_HALT;
                end
            end
            c_ST_HALT: begin
                // The MPU only honours RDY on read cycles, so its pending
                // writes must complete before the bus can be taken.
                if (bus.CPU_R_W) begin
                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                w_mem_r_w    = 1'b1;
                w_mem_abh    = r_pg;
                w_mem_abl    = r_cnt;
                w_mem_db_out = r_buf;
                w_state_nxt  = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                w_mem_r_w    = 1'b0;
                w_mem_abh    = c_DEST_ABH;
                w_mem_abl    = c_DEST_ABL;
                w_mem_db_out = r_buf;
                w_state_nxt  = (r_cnt == c_CNT_LAST) ? c_ST_IDLE : c_ST_READ;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.MEM_R_W    = w_mem_r_w;
    assign bus.MEM_ABL    = w_mem_abl;
    assign bus.MEM_ABH    = w_mem_abh;
    assign bus.MEM_DB_OUT = w_mem_db_out;
    assign bus.CPU_DB_IN  = bus.MEM_DB_IN;
    assign bus.CPU_RDY    = (r_state == c_ST_IDLE);
    assign bus.BUSY       = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_dma_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_arbiter
// Description : Self-checking bench for dma_arbiter. A transaction-queue model
//               predicts the bus every cycle; a vector table and directed
//               sequences cover reset, pass-through, HALT, page wrap,
//               re-trigger and reset abort; random traffic closes the run.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_arbiter;

    localparam logic [15:0] c_TRIG = 16'h4014;
    localparam logic [15:0] c_DEST = 16'h2004;
    localparam logic [15:0] c_CPU_RD = 16'hC123;

    logic CLK = 1'b0;
    logic RES_N;
    always #5 CLK = ~CLK;

    dma_arbiter_if bus();

    dma_arbiter #(
        .TRIG_ADDR(c_TRIG),
        .DEST_ADDR(c_DEST)
    ) dut (
        .CLK  (CLK),
        .RES_N(RES_N),
        .bus  (bus.master)
    );

    // Memory contents as a pure function of the address.
    function automatic logic [7:0] mem_pat(input logic [15:0] a);
        return (a[7:0] ^ 8'h5A) + {a[12:8], a[15:13]};
    endfunction

    assign bus.MEM_DB_IN = mem_pat({bus.MEM_ABH, bus.MEM_ABL});

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        rdy;
        logic        busy;
        logic [7:0]  dbin;
    } bus_t;

    typedef struct packed {
        logic        rw;
        logic [15:0] addr;
    } xfer_t;

    typedef struct {
        logic        rn;
        logic        rw;
        logic [15:0] a;
        logic [7:0]  d;
        bus_t        exp;
    } vec_t;

    int    n_chk = 0;
    int    n_err = 0;
    bus_t  obs;

    // Reference model: pending bus cycles of the current transfer.
    xfer_t       m_q[$];
    logic        m_halted = 1'b0;
    logic [7:0]  m_pg = 8'h00;
    logic [7:0]  m_buf = 8'h00;
    bit          m_valid = 1'b0;

    // Statistics for directed sequences.
    int          lo_cnt, rd_ok, rd_stray, wr_ok, dest_wr, busy_cnt;
    logic [7:0]  st_pg, st_lo;
    logic [15:0] last_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic bus_t mk(input logic rw, input logic [15:0] a, input logic [7:0] d,
                                input logic rdy, input logic busy);
        return {rw, a, d, rdy, busy, mem_pat(a)};
    endfunction

    task automatic clr_stats(input logic [7:0] pg);
        lo_cnt = 0; rd_ok = 0; rd_stray = 0; wr_ok = 0; dest_wr = 0; busy_cnt = 0;
        st_pg = pg; st_lo = 8'h00; last_rd = 16'h0000;
    endtask

    // One clock cycle: drive, sample at the falling edge, check, advance model.
    task automatic tick(input logic rn, input logic rw, input logic [15:0] a, input logic [7:0] d);
        bus_t e;
        RES_N          = rn;
        bus.CPU_R_W    = rw;
        bus.CPU_ABH    = a[15:8];
        bus.CPU_ABL    = a[7:0];
        bus.CPU_DB_OUT = d;
        @(negedge CLK);
        obs = {bus.MEM_R_W, bus.MEM_ABH, bus.MEM_ABL, bus.MEM_DB_OUT,
               bus.CPU_RDY, bus.BUSY, bus.CPU_DB_IN};
        if (m_valid) begin
            if (m_q.size() != 0) e = mk(m_q[0].rw, m_q[0].addr, m_buf, 1'b0, 1'b1);
            else                 e = mk(rw, a, d, !m_halted, m_halted);
            chk("bus", {29'd0, obs}, {29'd0, e});
        end
        if (!obs.rdy) lo_cnt++;
        if (obs.busy) busy_cnt++;
        if (obs.busy && obs.rw && !(rw && obs.addr == a)) begin
            if (obs.addr == {st_pg, st_lo}) begin
                rd_ok++;
                st_lo++;
            end else if (obs.addr[15:8] != st_pg) begin
                rd_stray++;
            end
            last_rd = obs.addr;
        end
        if (!obs.rw && obs.addr == c_DEST) begin
            dest_wr++;
            if (obs.busy && obs.dout == mem_pat(last_rd)) wr_ok++;
        end
        // Model advance at the coming rising edge.
        if (!rn) begin
            m_q.delete();
            m_halted = 1'b0;
            m_buf    = 8'h00;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (m_q.size() != 0) begin
                if (m_q[0].rw) m_buf = mem_pat(m_q[0].addr);
                void'(m_q.pop_front());
            end else if (m_halted) begin
                if (rw) begin
                    for (int k = 0; k < 256; k++) begin
                        m_q.push_back(xfer_t'({1'b1, m_pg, 8'(k)}));
                        m_q.push_back(xfer_t'({1'b0, c_DEST}));
                    end
                    m_halted = 1'b0;
                end
            end else if (!rw && a == c_TRIG) begin
                m_halted = 1'b1;
                m_pg     = d;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // MPU keeps reading until it is released.
    task automatic run_xfer(input string name);
        int n;
        n = 0;
        while (1) begin
            tick(1'b1, 1'b1, c_CPU_RD, 8'h00);
            n++;
            if (obs.rdy) break;
            if (n >= 2000) begin
                chk({name, "_timeout"}, 64'd0, 64'd1);
                break;
            end
        end
    endtask

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 16'h1234, 8'h00, mk(1'b1, 16'h1234, 8'h00, 1'b1, 1'b0)};
        tbl[1]  = '{1'b0, 1'b0, c_TRIG,   8'h07, mk(1'b0, c_TRIG,   8'h07, 1'b1, 1'b0)};
        tbl[2]  = '{1'b1, 1'b1, c_TRIG,   8'h07, mk(1'b1, c_TRIG,   8'h07, 1'b1, 1'b0)};
        tbl[3]  = '{1'b1, 1'b0, 16'h4015, 8'h02, mk(1'b0, 16'h4015, 8'h02, 1'b1, 1'b0)};
        tbl[4]  = '{1'b1, 1'b1, 16'h0000, 8'h00, mk(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0)};
        tbl[5]  = '{1'b1, 1'b0, c_TRIG,   8'h02, mk(1'b0, c_TRIG,   8'h02, 1'b1, 1'b0)};
        tbl[6]  = '{1'b1, 1'b0, 16'h01FD, 8'hAA, mk(1'b0, 16'h01FD, 8'hAA, 1'b0, 1'b1)};
        tbl[7]  = '{1'b1, 1'b0, 16'h01FC, 8'hBB, mk(1'b0, 16'h01FC, 8'hBB, 1'b0, 1'b1)};
        tbl[8]  = '{1'b1, 1'b1, 16'h8000, 8'h00, mk(1'b1, 16'h8000, 8'h00, 1'b0, 1'b1)};
        tbl[9]  = '{1'b1, 1'b1, 16'h8001, 8'h00, mk(1'b1, 16'h0200, 8'h00, 1'b0, 1'b1)};
        tbl[10] = '{1'b1, 1'b1, 16'h8001, 8'h00, mk(1'b0, c_DEST, mem_pat(16'h0200), 1'b0, 1'b1)};
        tbl[11] = '{1'b1, 1'b1, 16'h8001, 8'h00, mk(1'b1, 16'h0201, mem_pat(16'h0200), 1'b0, 1'b1)};
        tbl[12] = '{1'b1, 1'b1, 16'h8001, 8'h00, mk(1'b0, c_DEST, mem_pat(16'h0201), 1'b0, 1'b1)};

        clr_stats(8'h00);
        tick(1'b0, 1'b1, 16'h0000, 8'h00);
        tick(1'b0, 1'b1, 16'h0000, 8'h00);

        // Vector table: reset, non-trigger, trigger, two pushes in HALT, start.
        clr_stats(8'h02);
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].rn, tbl[i].rw, tbl[i].a, tbl[i].d);
            chk($sformatf("vec%0d", i), {29'd0, obs}, {29'd0, tbl[i].exp});
        end
        run_xfer("halt3");
        chk("halt3_rdy_low", 64'(lo_cnt), 64'd515);
        chk("halt3_reads",   64'(rd_ok),  64'd256);
        chk("halt3_writes",  64'(wr_ok),  64'd256);

        // Basic transfer: trigger directly followed by reads.
        clr_stats(8'h02);
        tick(1'b1, 1'b0, c_TRIG, 8'h02);
        run_xfer("basic");
        chk("basic_rdy_low", 64'(lo_cnt),   64'd513);
        chk("basic_reads",   64'(rd_ok),    64'd256);
        chk("basic_stray",   64'(rd_stray), 64'd0);
        chk("basic_writes",  64'(wr_ok),    64'd256);

        // Page FF: count wraps inside the page.
        clr_stats(8'hFF);
        tick(1'b1, 1'b0, c_TRIG, 8'hFF);
        run_xfer("pageff");
        chk("pageff_reads", 64'(rd_ok),    64'd256);
        chk("pageff_stray", 64'(rd_stray), 64'd0);
        chk("pageff_idle",  64'(obs.busy), 64'd0);

        // Re-trigger during HALT is ignored.
        clr_stats(8'h03);
        tick(1'b1, 1'b0, c_TRIG, 8'h03);
        tick(1'b1, 1'b0, c_TRIG, 8'h05);
        run_xfer("retrig");
        chk("retrig_reads",   64'(rd_ok),    64'd256);
        chk("retrig_stray",   64'(rd_stray), 64'd0);
        chk("retrig_rdy_low", 64'(lo_cnt),   64'd514);

        // Reset in WRITE with CNT=40 aborts the transfer for good.
        clr_stats(8'h02);
        tick(1'b1, 1'b0, c_TRIG, 8'h02);
        begin
            int n;
            n = 0;
            while (1) begin
                tick(1'b1, 1'b1, c_CPU_RD, 8'h00);
                n++;
                if (obs.busy && obs.rw && obs.addr == 16'h0240) break;
                if (n >= 1000) begin
                    chk("rst_find_timeout", 64'd0, 64'd1);
                    break;
                end
            end
        end
        tick(1'b0, 1'b1, c_CPU_RD, 8'h00);
        chk("rst_in_write", {48'd0, obs.addr}, {48'd0, c_DEST});
        tick(1'b0, 1'b1, 16'h1111, 8'h00);
        chk("rst_idle", {29'd0, obs}, {29'd0, mk(1'b1, 16'h1111, 8'h00, 1'b1, 1'b0)});
        dest_wr  = 0;
        busy_cnt = 0;
        for (int i = 0; i < 600; i++) tick(1'b1, 1'b1, 16'($urandom), 8'($urandom));
        chk("rst_no_dest", 64'(dest_wr),  64'd0);
        chk("rst_no_busy", 64'(busy_cnt), 64'd0);

        // Random traffic against the model.
        for (int i = 0; i < 15000; i++) begin
            logic        rn, rw;
            logic [15:0] a;
            rn = ($urandom_range(0, 999) != 0);
            rw = 1'($urandom_range(0, 1));
            a  = 16'($urandom);
            if ($urandom_range(0, 29) == 0) begin
                rw = 1'b0;
                a  = c_TRIG;
            end
            tick(rn, rw, a, 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
